// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Purpose:
//   Takes abstract instruction descriptors (lw, sw, add, sub, and, or, slt,
//   beq) and encodes them to RV32I machine code. The encoded words are written
//   sequentially into instruction memory starting at word 0. The CPU is held
//   in reset until the program is completely loaded.
//
// Optional feature (macro IMEM_NOP_PAD_EN):
//   When defined, the words after the final instruction are filled with nop
//   (0x00000013) up to DEPTH-1 before the load is reported done.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      descriptor valid
//   in_ready      loader can accept a descriptor
//   in_kind       0=LW 1=SW 2=ADD 3=SUB 4=AND 5=OR 6=SLT 7=BEQ
//   in_rd/rs1/rs2 register fields
//   in_imm        13-bit signed byte offset
//   in_last       descriptor is the final instruction
//   restart       pulse: start a new load from DONE or ERR
//   imem_we       single-cycle write strobe per word
//   imem_addr     word address of the write
//   imem_wdata    encoded instruction
//   cpu_hold      1 = keep the CPU in reset
//   load_done     program loaded
//   err           load aborted
//   word_count    words written so far
//   state_dbg     current FSM state (0=LOAD 1=DONE 2=ERR 3=PAD)
//
// Handshake: a descriptor transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready does not depend on in_valid. The encoded word
// appears on imem_* in the following cycle, and word_count has already
// advanced in that cycle.
// -----------------------------------------------------------------------------
module imem_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              err,
  output logic [ADDR_W:0]   word_count,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  localparam logic [2:0] K_LW  = 3'd0;
  localparam logic [2:0] K_SW  = 3'd1;
  localparam logic [2:0] K_ADD = 3'd2;
  localparam logic [2:0] K_SUB = 3'd3;
  localparam logic [2:0] K_AND = 3'd4;
  localparam logic [2:0] K_OR  = 3'd5;
  localparam logic [2:0] K_SLT = 3'd6;
  localparam logic [2:0] K_BEQ = 3'd7;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_DONE = 2'd1,
    S_ERR  = 2'd2,
    S_PAD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_q, last_d;   // word currently on imem_* carried in_last
  logic                xfer;

  function automatic logic [31:0] encode(input logic [2:0]  kind,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [12:0] imm);
    logic [31:0] w;
    w = '0;
    case (kind)
      K_LW:  w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      K_SW:  w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_ADD: w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_SUB: w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      K_AND: w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      K_OR:  w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      K_SLT: w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
      K_BEQ: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: w = '0;
    endcase
    return w;
  endfunction

  // LW/SW only carry a 12-bit immediate, so bit 12 must be a sign copy of
  // bit 11. BEQ offsets are halfword aligned.
  function automatic logic imm_ok(input logic [2:0] kind, input logic [12:0] imm);
    logic ok;
    ok = 1'b1;
    if ((kind == K_LW) || (kind == K_SW)) ok = (imm[12] == imm[11]);
    else if (kind == K_BEQ)               ok = ~imm[0];
    return ok;
  endfunction

  assign in_ready = (state_q == S_LOAD) && (wc_q < DEPTH_C);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (we_q && last_q) begin
`ifdef IMEM_NOP_PAD_EN
          // Start padding right away so the nops follow without a gap.
          if (wc_q < DEPTH_C) begin
            state_d = S_PAD;
            we_d    = 1'b1;
            addr_d  = wc_q[ADDR_W-1:0];
            wdata_d = NOP;
            wc_d    = wc_q + 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else if (we_q && (wc_q == DEPTH_C)) begin
          // Memory filled without seeing the final instruction.
          state_d = S_ERR;
        end else if (xfer) begin
          if (!imm_ok(in_kind, in_imm)) begin
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = wc_q[ADDR_W-1:0];
            wdata_d = encode(in_kind, in_rd, in_rs1, in_rs2, in_imm);
            last_d  = in_last;
            wc_d    = wc_q + 1'b1;
          end
        end
      end
      S_PAD: begin
        if (wc_q < DEPTH_C) begin
          we_d    = 1'b1;
          addr_d  = wc_q[ADDR_W-1:0];
          wdata_d = NOP;
          wc_d    = wc_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_LOAD;
          wc_d    = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
//
// Directed bench for imem_program_loader built with DEPTH=4, ADDR_W=2.
// Inputs change 1 ns after the rising edge; direct checks are made at the
// same point, and a monitor compares every memory write on the falling edge
// against an expected queue of {addr, data}.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  localparam logic [2:0] K_LW  = 3'd0;
  localparam logic [2:0] K_SW  = 3'd1;
  localparam logic [2:0] K_ADD = 3'd2;
  localparam logic [2:0] K_SUB = 3'd3;
  localparam logic [2:0] K_AND = 3'd4;
  localparam logic [2:0] K_OR  = 3'd5;
  localparam logic [2:0] K_SLT = 3'd6;
  localparam logic [2:0] K_BEQ = 3'd7;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last), .restart(restart),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .err(err),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_wr(input int a, input logic [31:0] d);
    logic [63:0] v;
    v = '0;
    v[33:32] = 2'(a);
    v[31:0]  = d;
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() > 0) check("imem_write", {30'b0, imem_addr, imem_wdata}, exp_q.pop_front());
      else check("unexpected_write", {30'b0, imem_addr, imem_wdata}, 64'hdead);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    in_valid = 1'b1;
    in_kind  = kind;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
  endtask

  // One descriptor, one transfer; returns in the cycle its write is visible.
  task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm, input logic last);
    check("ready_before_send", in_ready, 1);
    set_desc(kind, rd, rs1, rs2, imm, last);
    step();
    in_valid = 1'b0;
  endtask

  // Called in the cycle the in_last word is on imem_*; wc = words written.
  task automatic finish_load(input int wc);
    int n;
    check("not_done_yet", load_done, 0);
`ifdef IMEM_NOP_PAD_EN
    for (int a = wc; a < DEPTH; a++) expect_wr(a, 32'h0000_0013);
    n = DEPTH - wc + 1;
`else
    n = 1;
`endif
    for (int i = 0; i < n - 1; i++) step();
    check("done_low_before_entry", load_done, 0);
    step();
    check("load_done", load_done, 1);
    check("cpu_hold_done", cpu_hold, 0);
    check("err_done", err, 0);
    check("ready_done", in_ready, 0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_word_count", word_count, 0);
    check("rs_load_done", load_done, 0);
    check("rs_err", err, 0);
    check("rs_cpu_hold", cpu_hold, 1);
    check("rs_ready", in_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 1);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;
    step();
    check_reset_values("after_reset");

    // Single ADD x3,x1,x2 (last)
    expect_wr(0, 32'h0020_81B3);
    send(K_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
    check("add_we", imem_we, 1);
    check("add_addr", imem_addr, 0);
    check("add_wdata", imem_wdata, 32'h0020_81B3);
    check("add_count", word_count, 1);
    finish_load(1);
    do_restart();

    // Back-to-back SUB / LW / SW(last)
    expect_wr(0, 32'h4073_02B3);
    expect_wr(1, 32'h0081_2203);
    expect_wr(2, 32'h0050_A623);
    set_desc(K_SUB, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0);
    step();
    check("b2b_ready1", in_ready, 1);
    set_desc(K_LW, 5'd4, 5'd2, 5'd9, 13'd8, 1'b0);
    step();
    check("b2b_we1", imem_we, 1);
    set_desc(K_SW, 5'd17, 5'd1, 5'd5, 13'd12, 1'b1);
    step();
    in_valid = 1'b0;
    check("b2b_we2", imem_we, 1);
    check("b2b_count", word_count, 3);
    finish_load(3);
    do_restart();

    // BEQ -8 (rd ignored), then BEQ with odd offset -> error
    expect_wr(0, 32'hFE20_8CE3);
    send(K_BEQ, 5'd31, 5'd1, 5'd2, -13'sd8, 1'b0);
    check("beq_wdata", imem_wdata, 32'hFE20_8CE3);
    step();
    send(K_BEQ, 5'd0, 5'd1, 5'd2, 13'd5, 1'b0);
    check("beq_bad_we", imem_we, 0);
    check("beq_bad_err", err, 1);
    check("beq_bad_hold", cpu_hold, 1);
    check("beq_bad_ready", in_ready, 0);
    check("beq_bad_count", word_count, 1);

    // Restart from ERR, ADD with a simultaneous restart (ignored in LOAD)
    do_restart();
    expect_wr(0, 32'h0020_81B3);
    restart = 1'b1;
    send(K_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
    restart = 1'b0;
    check("rs_add_addr", imem_addr, 0);
    check("rs_add_count", word_count, 1);
    finish_load(1);
    do_restart();

    // Overflow: AND, OR, SLT, SW -4 with no in_last
    expect_wr(0, 32'h0031_70B3);
    expect_wr(1, 32'h0031_60B3);
    expect_wr(2, 32'h0031_20B3);
    expect_wr(3, 32'hFE74_2E23);
    set_desc(K_AND, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    step();
    set_desc(K_OR, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    step();
    set_desc(K_SLT, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0);
    step();
    set_desc(K_SW, 5'd9, 5'd8, 5'd7, -13'sd4, 1'b0);
    step();
    // keep in_valid high: no further transfer may happen
    check("ovf_addr", imem_addr, 3);
    check("ovf_count", word_count, 4);
    check("ovf_ready", in_ready, 0);
    check("ovf_err_early", err, 0);
    step();
    check("ovf_err", err, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_we", imem_we, 0);
    step();
    in_valid = 1'b0;

    // LW with out-of-range immediate -> error, nothing written
    do_restart();
    send(K_LW, 5'd1, 5'd2, 5'd0, 13'h0800, 1'b0);
    check("lw_bad_err", err, 1);
    check("lw_bad_count", word_count, 0);

    // Reset in the middle of a load
    do_restart();
    expect_wr(0, 32'h0020_81B3);
    send(K_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
    set_desc(K_SUB, 5'd5, 5'd6, 5'd7, 13'd0, 1'b0);
    rst = 1'b1;
    step();
    in_valid = 1'b0;
    check_reset_values("midload_reset");
    rst = 1'b0;
    step();
    step();

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Instruction encoder and loader for the single-cycle RV32I core. It is the producer side of the instruction decoder.
- Accepts abstract instruction descriptors over a valid/ready handshake and encodes them to 32-bit machine code (lw, sw, add, sub, and, or, slt, beq).
- Writes the encoded words sequentially into instruction memory.
- Holds the CPU in reset until the program is fully loaded.

Parameters:
- ADDR_W, 8, word-address width of instruction memory.
- DEPTH, 256, number of instruction words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  loader can accept a descriptor.
- in_kind  in  3  0=LW 1=SW 2=ADD 3=SUB 4=AND 5=OR 6=SLT 7=BEQ.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  13  signed immediate (byte offset).
- in_last  in  1  descriptor is the final instruction.
- restart  in  1  pulse; begin a new load from DONE or ERR.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- cpu_hold  out  1  1 = keep CPU in reset.
- load_done  out  1  program loaded.
- err  out  1  load aborted.
- word_count  out  ADDR_W+1  words written so far.

Behaviour:
- Reset values: state=LOAD, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, err=0, word_count=0. A reset mid-load abandons the load immediately; partially written memory is not cleared.
- States: LOAD, DONE, ERR (plus PAD when the optional feature is enabled).
- Handshake: in_ready = (state==LOAD) && (word_count < DEPTH). A transfer occurs when in_valid && in_ready.
- One-cycle latency: a transfer in cycle N gives imem_we=1, imem_addr=word_count, imem_wdata=encoding in cycle N+1. word_count increments in that same cycle. imem_we is a single-cycle pulse per word. Back-to-back transfers sustain one write per cycle.
- Encoding (fields in RV32I order):
  - LW: imm[11:0] | rs1 | 010 | rd | 0000011.
  - SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - R-type (opcode 0110011):
    - ADD: f3 000, f7 0000000.
    - SUB: f3 000, f7 0100000.
    - AND: f3 111.
    - OR: f3 110.
    - SLT: f3 010.
    - All other R-type funct7 = 0.
  - BEQ: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011.
- Don't-care fields: unused descriptor fields are ignored (e.g. in_rd for SW/BEQ).
- Immediate check: for LW/SW, in_imm[12] must equal in_imm[11]. For BEQ, in_imm[0] must be 0.
  - On violation the descriptor is accepted but not written.
  - Next cycle: state→ERR, err=1.
- Overflow: if the word written to address DEPTH-1 did not carry in_last, state→ERR and err=1 in the cycle after that write.
- Completion: in the cycle after the in_last write, state→DONE, load_done=1, cpu_hold=0.
- DONE/ERR: in_ready=0. cpu_hold stays 0 in DONE and 1 in ERR.
  - restart=1 moves to LOAD next cycle, with word_count=0, load_done=0, err=0, cpu_hold=1.
  - restart is ignored in LOAD.
- Simultaneous transfer and restart in LOAD: the transfer wins; restart is ignored.

Optional Feature:
- Macro: IMEM_NOP_PAD_EN.
- Defined: after the in_last write, enter PAD instead of DONE.
  - Write 0x00000013 (nop) to each remaining address, one per cycle, up to DEPTH-1.
  - Then go to DONE. load_done and cpu_hold change only on entering DONE.
  - If in_last was written at DEPTH-1, go directly to DONE.
- Undefined: no PAD state; completion goes straight to DONE.

Test Plan:
- Single ADD rd=3 rs1=1 rs2=2 with in_last → next cycle imem_we=1, addr=0, wdata=0x002081B3; following cycle load_done=1, cpu_hold=0.
- Back-to-back SUB x5,x6,x7 / LW x4,8(x2) / SW x5,12(x1) (last) → consecutive writes 0x407302B3@0, 0x00812203@1, 0x0050A623@2; word_count=3.
- BEQ rs1=1 rs2=2 imm=-8 → wdata=0xFE208CE3. BEQ with imm=5 → no write; err=1, cpu_hold=1, in_ready=0.
- DEPTH=4, four descriptors with in_last=0 → writes at 0..3, in_ready=0 after the 4th; err=1 in the cycle after the addr-3 write.
- From ERR, pulse restart, then load one ADD → write at addr 0, word_count=1, load_done=1. rst asserted mid-load → all outputs return to reset values next cycle.
- IMEM_NOP_PAD_EN, DEPTH=4, one LW (last) → 0x00812203@0, then 0x00000013 @1, @2, @3; load_done rises the cycle after the addr-3 write.
